jpeg_block_sequencer: RTL and testbench
=======================================

Name: jpeg_block_sequencer

Overview:
- Controller that sequences one 8x8 block through the single-component JPEG encoder datapath.
- Accepts a 64-pixel RGB stream under a valid/ready handshake and aligns pixel strobes with the RGB-to-YCbCr pipeline delay.
- Drives the encoder control strobes: buffer clear, pixel load, DCT, DCT end, zigzag load, zigzag row scan, Huffman start.
- Replaces the bench-driven control pins at the encoder top; one instance serves the Y path.

Parameters:
- RGB_LAT, 1: cycles from pixel acceptance to Y_data valid (RGB_to_YCbCr pipeline depth); legal 0..4.
- DCT_CYCLES, 8: cycles dct_enable is held high; legal 1..255.
- ZZ_ROWS, 8: zigzag rows scanned; matrix_row counts 0..ZZ_ROWS-1.

Ports:
- clock, input, 1: single clock.
- reset_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin one block; sampled only in IDLE.
- abort, input, 1: synchronous return to IDLE from any state.
- pix_valid, input, 1: RGB pixel present.
- pix_ready, output, 1: sequencer accepts a pixel this cycle.
- huffman_done, input, 1: level from the Huffman stage; sampled only in HUFF_WAIT.
- input_enable, output, 1: one-cycle buffer clear/arm.
- input_1pix_enable, output, 1: Y_data valid strobe to the pixel buffer.
- dct_enable, output, 1: DCT run.
- dct_end_enable, output, 1: one-cycle DCT completion strobe.
- zigzag_input_enable, output, 1: one-cycle zigzag load strobe.
- zigag_enable, output, 1: zigzag scan active.
- matrix_row, output, 8: current zigzag row.
- Huffman_start, output, 1: one-cycle Huffman kick.
- busy, output, 1: state is not IDLE.
- block_done, output, 1: one-cycle pulse when the block completes.

Behaviour:
- Reset values: all outputs 0, matrix_row=0, state IDLE, pixel count 0, align shift register cleared.
- All strobes are registered, Moore-style. pix_ready is the only combinational output, equal to (state==LOAD && pix_cnt<64).
- IDLE: when start=1 at an edge, state becomes LOAD and input_enable=1 for exactly the next cycle. start outside IDLE is ignored.
- LOAD: each cycle with pix_valid&&pix_ready increments the 7-bit pix_cnt. The accept is pushed into an RGB_LAT-deep shift register; its output drives input_1pix_enable, so the strobe is high exactly RGB_LAT cycles after the accept edge. With RGB_LAT=0 the strobe is the registered accept (1 cycle). pix_valid while pix_ready=0 is ignored. Gaps in pix_valid are allowed.
- On the 64th accept, state becomes DRAIN and pix_ready=0 on the next cycle.
- DRAIN: wait until the shift register is empty (last input_1pix_enable has fired), then go to DCT.
- DCT: dct_enable=1 for exactly DCT_CYCLES consecutive cycles, then DCT_END.
- DCT_END: dct_end_enable=1 for 1 cycle, then ZZ_LOAD.
- ZZ_LOAD: zigzag_input_enable=1 for 1 cycle, then ZZ.
- ZZ: zigag_enable=1 for ZZ_ROWS cycles, with matrix_row=0,1,..,ZZ_ROWS-1 one per cycle. matrix_row returns to 0 on exit. Then HUFF_START.
- HUFF_START: Huffman_start=1 for 1 cycle, then HUFF_WAIT.
- HUFF_WAIT: when huffman_done=1, block_done=1 for 1 cycle and state returns to IDLE. A start in that same cycle is not honoured; start is accepted from the following cycle.
- abort (highest priority after reset): at the next edge, state is IDLE, all strobes 0, pix_cnt=0, shift register cleared, block_done stays 0. In-flight pixels are dropped.
- reset_n low mid-operation: everything returns to reset values immediately (asynchronous).
- Counters never wrap: pix_cnt saturates logically at 64 via the state change; the DCT and row counters are reloaded on state entry.

Optional Feature:
- Macro: JPEG_SEQ_PERF_EN.
- Enabled: adds outputs blk_count[15:0] (incremented on block_done, wraps at 65535->0) and last_blk_cycles[15:0] (cycles from the start accept to block_done, saturating at 0xFFFF). Both reset to 0 and are unaffected by abort.
- Disabled: these ports and their logic do not exist.

Decomposition:
- Package jpeg_seq_pkg: state enum (IDLE, LOAD, DRAIN, DCT, DCT_END, ZZ_LOAD, ZZ, HUFF_START, HUFF_WAIT) and constant BLK_PIXELS=64.
- Sub-module jpeg_strobe_align: a parameterised RGB_LAT-deep 1-bit delay line with synchronous clear (used by abort) and an empty flag.

Test Plan:
- Nominal block, RGB_LAT=1, DCT_CYCLES=8, pix_valid always 1: input_enable 1 cycle; 64 input_1pix_enable pulses, each 1 cycle after its accept; dct_enable 8 cycles; matrix_row 0..7; Huffman_start once; block_done 1 cycle after huffman_done.
- Bursty input, pix_valid toggling 1/0: exactly 64 accepts; pix_ready=0 from the cycle after the 64th accept; no 65th input_1pix_enable.
- RGB_LAT=3: DCT entry occurs only after the 64th input_1pix_enable, which fires 3 cycles after the last accept.
- abort asserted during ZZ at matrix_row=4: next cycle state is IDLE, zigag_enable=0, matrix_row=0, no Huffman_start and no block_done. A following start runs a clean block.
- reset_n pulsed low during DCT: all outputs 0 immediately; start held during HUFF_WAIT is ignored.
- With JPEG_SEQ_PERF_EN, 3 back-to-back blocks: blk_count=3 and last_blk_cycles equals the measured cycle count.

Source files
------------

// File: rtl/jpeg_seq_pkg.sv
// Shared state encoding, block size and saturating helper for the JPEG block sequencer.
package jpeg_seq_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LOAD       = 4'd1,
    DRAIN      = 4'd2,
    DCT        = 4'd3,
    DCT_END    = 4'd4,
    ZZ_LOAD    = 4'd5,
    ZZ         = 4'd6,
    HUFF_START = 4'd7,
    HUFF_WAIT  = 4'd8
  } state_t;

  localparam int unsigned BLK_PIXELS = 64;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

endpackage

// File: rtl/jpeg_block_sequencer_align.sv
// RGB_LAT-deep 1-bit delay line that lines pixel accepts up with Y_data valid.
// A latency of 0 still costs one register so the strobe is always registered.
module jpeg_strobe_align #(
  parameter int unsigned LAT = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_in,
  output logic o_out,
  output logic o_empty
);

  localparam int unsigned DEPTH = (LAT == 0) ? 1 : LAT;

  logic [DEPTH-1:0] r_sr;

  // Shift register; a synchronous clear drops every in-flight pixel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sr <= {DEPTH{1'b0}};
    end else if (i_clr) begin
      r_sr <= {DEPTH{1'b0}};
    end else begin
      r_sr[0] <= i_in;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_out   = r_sr[DEPTH-1];
  assign o_empty = (r_sr == {DEPTH{1'b0}});

endmodule

// File: rtl/jpeg_block_sequencer.sv
// Sequences one 8x8 block through the Y-path JPEG encoder and drives its control strobes.
// Optional JPEG_SEQ_PERF_EN adds block and cycle counters (blk_count, last_blk_cycles).
module jpeg_block_sequencer
  import jpeg_seq_pkg::*;
#(
  parameter int unsigned RGB_LAT    = 1,
  parameter int unsigned DCT_CYCLES = 8,
  parameter int unsigned ZZ_ROWS    = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic       huffman_done,
  output logic       input_enable,
  output logic       input_1pix_enable,
  output logic       dct_enable,
  output logic       dct_end_enable,
  output logic       zigzag_input_enable,
  output logic       zigag_enable,
  output logic [7:0] matrix_row,
  output logic       Huffman_start,
  output logic       busy,
  output logic       block_done
`ifdef JPEG_SEQ_PERF_EN
  ,
  output logic [15:0] blk_count,
  output logic [15:0] last_blk_cycles
`endif
);

  state_t     r_state;
  state_t     w_next;
  logic [6:0] r_pix_cnt;
  logic [7:0] r_dct_cnt;
  logic [7:0] r_row;
  logic       r_input_enable, r_dct_enable, r_dct_end, r_zz_load, r_zz_en;
  logic       r_huff_start, r_busy, r_block_done;
  logic       w_accept, w_align_empty, w_dct_done, w_last_row, w_blk_done;

  assign pix_ready  = (r_state == LOAD) && (r_pix_cnt < 7'(BLK_PIXELS));
  assign w_accept   = pix_valid && pix_ready;
  assign w_dct_done = (r_dct_cnt == 8'(DCT_CYCLES - 1));
  assign w_last_row = (r_row == 8'(ZZ_ROWS - 1));
  // abort suppresses a completion seen in the same cycle
  assign w_blk_done = (r_state == HUFF_WAIT) && huffman_done && !abort;

  jpeg_strobe_align #(.LAT(RGB_LAT)) u_align (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clr   (abort),
    .i_in    (w_accept),
    .o_out   (input_1pix_enable),
    .o_empty (w_align_empty)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort overrides every state.
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:       if (start) w_next = LOAD; else w_next = IDLE;
        LOAD:       if (w_accept && (r_pix_cnt == 7'(BLK_PIXELS - 1))) w_next = DRAIN; else w_next = LOAD;
        DRAIN:      if (w_align_empty) w_next = DCT; else w_next = DRAIN;
        DCT:        if (w_dct_done) w_next = DCT_END; else w_next = DCT;
        DCT_END:    w_next = ZZ_LOAD;
        ZZ_LOAD:    w_next = ZZ;
        ZZ:         if (w_last_row) w_next = HUFF_START; else w_next = ZZ;
        HUFF_START: w_next = HUFF_WAIT;
        HUFF_WAIT:  if (huffman_done) w_next = IDLE; else w_next = HUFF_WAIT;
        default:    w_next = IDLE;
      endcase
    end
  end

  // Counters reload on state entry, so none of them can wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_cnt <= 7'd0;
      r_dct_cnt <= 8'd0;
      r_row     <= 8'd0;
    end else begin
      if (abort || (r_state == IDLE)) begin
        r_pix_cnt <= 7'd0;
      end else if (w_accept) begin
        r_pix_cnt <= r_pix_cnt + 7'd1;
      end
      r_dct_cnt <= ((r_state == DCT) && (w_next == DCT)) ? r_dct_cnt + 8'd1 : 8'd0;
      r_row     <= ((r_state == ZZ) && (w_next == ZZ)) ? r_row + 8'd1 : 8'd0;
    end
  end

  // Strobes are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_input_enable <= 1'b0;
      r_dct_enable   <= 1'b0;
      r_dct_end      <= 1'b0;
      r_zz_load      <= 1'b0;
      r_zz_en        <= 1'b0;
      r_huff_start   <= 1'b0;
      r_busy         <= 1'b0;
      r_block_done   <= 1'b0;
    end else begin
      r_input_enable <= (r_state == IDLE) && (w_next == LOAD);
      r_dct_enable   <= (w_next == DCT);
      r_dct_end      <= (w_next == DCT_END);
      r_zz_load      <= (w_next == ZZ_LOAD);
      r_zz_en        <= (w_next == ZZ);
      r_huff_start   <= (w_next == HUFF_START);
      r_busy         <= (w_next != IDLE);
      r_block_done   <= w_blk_done;
    end
  end

  assign input_enable        = r_input_enable;
  assign dct_enable          = r_dct_enable;
  assign dct_end_enable      = r_dct_end;
  assign zigzag_input_enable = r_zz_load;
  assign zigag_enable        = r_zz_en;
  assign matrix_row          = r_row;
  assign Huffman_start       = r_huff_start;
  assign busy                = r_busy;
  assign block_done          = r_block_done;

`ifdef JPEG_SEQ_PERF_EN
  logic [15:0] r_blk_count, r_cyc, r_last;

  // Block counter and start-to-done cycle measurement; abort leaves them alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_blk_count <= 16'd0;
      r_cyc       <= 16'd0;
      r_last      <= 16'd0;
    end else begin
      if ((r_state == IDLE) && (w_next == LOAD)) begin
        r_cyc <= 16'd1;
      end else if (r_state != IDLE) begin
        r_cyc <= sat_inc16(r_cyc);
      end
      if (w_blk_done) begin
        r_blk_count <= r_blk_count + 16'd1;
        r_last      <= sat_inc16(r_cyc);
      end
    end
  end

  assign blk_count       = r_blk_count;
  assign last_blk_cycles = r_last;
`endif

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Randomized bench: two sequencer configurations checked cycle by cycle against a block timeline model.
// Define JPEG_SEQ_PERF_EN to also check blk_count / last_blk_cycles.
`timescale 1ns/1ps
module tb_jpeg_block_sequencer;

  localparam int MAXC = 1024;

  logic       clk_s = 1'b0;
  logic       rst_n_s;
  logic       st_s [2], ab_s [2], pv_s [2], hd_s [2];
  logic       rdy_s [2], ie_s [2], p1_s [2], de_s [2], dend_s [2];
  logic       zi_s [2], zz_s [2], hst_s [2], busy_s [2], bd_s [2];
  logic [7:0] row_s [2];
`ifdef JPEG_SEQ_PERF_EN
  logic [15:0] bc_s [2], lc_s [2];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int blk_no  = 0;
  int blk_m [2];
  int last_m [2];
  bit chained [2];

  always #5 clk_s = ~clk_s;

  jpeg_block_sequencer #(.RGB_LAT(1), .DCT_CYCLES(8), .ZZ_ROWS(8)) dut0 (
    .clock(clk_s), .reset_n(rst_n_s), .start(st_s[0]), .abort(ab_s[0]),
    .pix_valid(pv_s[0]), .pix_ready(rdy_s[0]), .huffman_done(hd_s[0]),
    .input_enable(ie_s[0]), .input_1pix_enable(p1_s[0]), .dct_enable(de_s[0]),
    .dct_end_enable(dend_s[0]), .zigzag_input_enable(zi_s[0]), .zigag_enable(zz_s[0]),
    .matrix_row(row_s[0]), .Huffman_start(hst_s[0]), .busy(busy_s[0]), .block_done(bd_s[0])
`ifdef JPEG_SEQ_PERF_EN
    , .blk_count(bc_s[0]), .last_blk_cycles(lc_s[0])
`endif
  );

  jpeg_block_sequencer #(.RGB_LAT(3), .DCT_CYCLES(5), .ZZ_ROWS(6)) dut1 (
    .clock(clk_s), .reset_n(rst_n_s), .start(st_s[1]), .abort(ab_s[1]),
    .pix_valid(pv_s[1]), .pix_ready(rdy_s[1]), .huffman_done(hd_s[1]),
    .input_enable(ie_s[1]), .input_1pix_enable(p1_s[1]), .dct_enable(de_s[1]),
    .dct_end_enable(dend_s[1]), .zigzag_input_enable(zi_s[1]), .zigag_enable(zz_s[1]),
    .matrix_row(row_s[1]), .Huffman_start(hst_s[1]), .busy(busy_s[1]), .block_done(bd_s[1])
`ifdef JPEG_SEQ_PERF_EN
    , .blk_count(bc_s[1]), .last_blk_cycles(lc_s[1])
`endif
  );

  function automatic int lat_of(input int d); return (d == 0) ? 1 : 3; endfunction
  function automatic int dct_of(input int d); return (d == 0) ? 8 : 5; endfunction
  function automatic int zz_of(input int d);  return (d == 0) ? 8 : 6; endfunction

  function automatic logic [17:0] obs_vec(input int d);
    return {busy_s[d], rdy_s[d], ie_s[d], p1_s[d], de_s[d], dend_s[d],
            zi_s[d], zz_s[d], row_s[d], hst_s[d], bd_s[d]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n_s = 1'b0;
    for (int d = 0; d < 2; d++) begin
      st_s[d] = 1'b0; ab_s[d] = 1'b0; pv_s[d] = 1'b0; hd_s[d] = 1'b0;
      blk_m[d] = 0; last_m[d] = 0; chained[d] = 1'b0;
    end
    repeat (3) @(posedge clk_s);
    @(negedge clk_s);
    rst_n_s = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("reset_outputs dut%0d", d), 32'(obs_vec(d)), 32'd0);
`ifdef JPEG_SEQ_PERF_EN
      check_eq("reset_blk_count", 32'(bc_s[d]), 32'd0);
      check_eq("reset_last_cycles", 32'(lc_s[d]), 32'd0);
`endif
    end
  endtask

  // mode 0: full block, 1: abort at cycle k, 2: reset_n pulse at cycle k.
  // ksel 0: random k, 1: ZZ row 4, 2: third DCT cycle. Cycle 0 carries the start.
  task automatic run_block(input int d, input int mode, input int ksel, input int pv_pct,
                           input int hwait, input bit chain_next);
    bit strobe [MAXC];
    bit pvpat [MAXC];
    int acc, last_acc, t, dcts, dcte, de, zl, zs, ze, hs, w, hdone, bd, k, tend, t0, stmax;
    bit zon, zero_out;
    logic [17:0] e;
    blk_no++;
    for (int i = 0; i < MAXC; i++) begin
      strobe[i] = 1'b0;
      pvpat[i]  = 1'b0;
    end
    acc = 0; last_acc = 0; t = 1;
    while (acc < 64 && t < 700) begin
      pvpat[t] = (pv_pct < 0) ? t[0] : (int'($urandom_range(99)) < pv_pct);
      if (pvpat[t]) begin
        acc++;
        last_acc = t;
        strobe[t + lat_of(d)] = 1'b1;
      end
      t++;
    end
    dcts  = last_acc + lat_of(d) + 2;
    dcte  = dcts + dct_of(d) - 1;
    de    = dcte + 1;
    zl    = de + 1;
    zs    = zl + 1;
    ze    = zs + zz_of(d) - 1;
    hs    = ze + 1;
    w     = hs + 1;
    hdone = w + hwait;
    bd    = hdone + 1;
    case (ksel)
      1:       k = zs + 4;
      2:       k = dcts + 2;
      default: k = int'($urandom_range(bd - 1, 1));
    endcase
    tend  = (mode == 0) ? bd : k + 2;
    stmax = (mode == 0) ? hdone : ((mode == 1) ? k : k - 1);
    t0    = chained[d] ? 1 : 0;
    for (int c = t0; c <= tend; c++) begin
      @(posedge clk_s);
      #1;
      st_s[d] = (c == 0) || ((mode == 0) && (c == bd) && chain_next) ||
                ((c >= 1) && (c <= stmax) && ($urandom_range(1) == 1));
      ab_s[d] = (mode == 1) && (c == k);
      pv_s[d] = ((c >= 1) && (c <= last_acc)) ? pvpat[c] : 1'($urandom_range(1));
      hd_s[d] = (c < w) ? 1'($urandom_range(1)) : (c == hdone);
      if ((mode == 2) && (c == k)) begin
        #1 rst_n_s = 1'b0;
      end
      @(negedge clk_s);
      zon      = (c >= zs) && (c <= ze);
      zero_out = ((mode == 1) && (c > k)) || ((mode == 2) && (c >= k));
      e = zero_out ? 18'd0 :
          {(c >= 1) && (c < bd), (c >= 1) && (c <= last_acc), (c == 1), strobe[c],
           (c >= dcts) && (c <= dcte), (c == de), (c == zl), zon,
           zon ? 8'(c - zs) : 8'd0, (c == hs), (c == bd)};
      check_eq($sformatf("outputs dut%0d blk%0d cyc%0d", d, blk_no, c), 32'(obs_vec(d)), 32'(e));
`ifdef JPEG_SEQ_PERF_EN
      if ((mode == 0) && (c == bd)) begin
        blk_m[d]++;
        last_m[d] = bd;
      end
      if ((mode == 2) && (c == k)) begin
        blk_m[0] = 0; blk_m[1] = 0; last_m[0] = 0; last_m[1] = 0;
      end
      if ((c == tend) || ((mode == 2) && (c == k))) begin
        check_eq($sformatf("blk_count dut%0d blk%0d", d, blk_no), 32'(bc_s[d]), 32'(blk_m[d] & 32'hFFFF));
        check_eq($sformatf("last_blk_cycles dut%0d blk%0d", d, blk_no), 32'(lc_s[d]), 32'(last_m[d]));
      end
`endif
      if ((mode == 2) && (c == k)) begin
        rst_n_s = 1'b1;
        chained[0] = 1'b0;
        chained[1] = 1'b0;
      end
    end
    chained[d] = (mode == 0) && chain_next;
  endtask

  initial begin
    do_reset();
    run_block(0, 0, 0, 100, 3, 1'b0);   // nominal, pix_valid always high
    run_block(0, 0, 0, -1, 0, 1'b0);    // pix_valid toggling 1/0
    run_block(1, 0, 0, 100, 2, 1'b0);   // RGB_LAT=3 drain
    run_block(0, 1, 1, 70, 2, 1'b0);    // abort at matrix_row 4
    run_block(0, 0, 0, 80, 1, 1'b0);    // clean block after abort
    run_block(1, 2, 2, 90, 1, 1'b0);    // reset_n pulse during DCT
    run_block(1, 0, 0, 60, 4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_block(int'($urandom_range(1)), 1, 0, int'($urandom_range(100, 40)),
                int'($urandom_range(5)), 1'b0);
    end
    for (int d = 0; d < 2; d++) begin
      run_block(d, 0, 0, int'($urandom_range(100, 50)), int'($urandom_range(3)), 1'b1);
      run_block(d, 0, 0, int'($urandom_range(100, 50)), int'($urandom_range(3)), 1'b1);
      run_block(d, 0, 0, int'($urandom_range(100, 50)), int'($urandom_range(3)), 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
